// File: rtl/pmod_gpio_arbiter.sv
// pmod_gpio_arbiter: two-requester owner arbiter for one shared Pmod GPIO port.
// Round-robin grants, optional hold preemption, high-Z turnaround, synced pin inputs.
module pmod_gpio_arbiter #(
    parameter int WIDTH       = 8,
    parameter int TURNAROUND  = 2,
    parameter int MAX_HOLD    = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             preempt,
    input  logic [WIDTH-1:0] rq0_tri_t,
    input  logic [WIDTH-1:0] rq1_tri_t,
    input  logic [WIDTH-1:0] rq0_tri_o,
    input  logic [WIDTH-1:0] rq1_tri_o,
    output logic [WIDTH-1:0] rq0_tri_i,
    output logic [WIDTH-1:0] rq1_tri_i,
    output logic [WIDTH-1:0] pmod_tri_t,
    output logic [WIDTH-1:0] pmod_tri_o,
    input  logic [WIDTH-1:0] pmod_tri_i
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GRANT0 = 2'd1;
    localparam logic [1:0] S_GRANT1 = 2'd2;
    localparam logic [1:0] S_TURN   = 2'd3;

    localparam logic [3:0]  TURN_LOAD  = 4'(TURNAROUND - 1);
    localparam bit          HOLD_EN    = (MAX_HOLD != 0);
    localparam logic [15:0] HOLD_LIMIT = 16'(HOLD_EN ? MAX_HOLD - 1 : 0);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             take_preempt;
    logic             last_owner;
    logic [3:0]       turn_cnt;
    logic [15:0]      hold_cnt;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    assign gnt0 = (state == S_GRANT0);
    assign gnt1 = (state == S_GRANT1);

    assign rq0_tri_i = gnt0 ? sync_q[SYNC_STAGES-1] : '0;
    assign rq1_tri_i = gnt1 ? sync_q[SYNC_STAGES-1] : '0;

    // Next-state arbitration; owner drop wins over preemption
    always_comb begin
        state_nxt    = state;
        take_preempt = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req0 && (!req1 || last_owner))
                    state_nxt = S_GRANT0;
                else if (req1)
                    state_nxt = S_GRANT1;
            end
            S_GRANT0: begin
                if (!req0) begin
                    state_nxt = S_TURN;
                end else if (HOLD_EN && req1 && hold_cnt >= HOLD_LIMIT) begin
                    state_nxt    = S_TURN;
                    take_preempt = 1'b1;
                end
            end
            S_GRANT1: begin
                if (!req1) begin
                    state_nxt = S_TURN;
                end else if (HOLD_EN && req0 && hold_cnt >= HOLD_LIMIT) begin
                    state_nxt    = S_TURN;
                    take_preempt = 1'b1;
                end
            end
            default: begin
                if (turn_cnt == 4'd0)
                    state_nxt = S_IDLE;
            end
        endcase
    end

    // State, preempt pulse and ownership bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            preempt    <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            state   <= state_nxt;
            preempt <= take_preempt;
            if (state == S_IDLE && state_nxt == S_GRANT0)
                last_owner <= 1'b0;
            else if (state == S_IDLE && state_nxt == S_GRANT1)
                last_owner <= 1'b1;
        end
    end

    // Turnaround down-counter and saturating hold counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            turn_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            if (state != S_TURN && state_nxt == S_TURN)
                turn_cnt <= TURN_LOAD;
            else if (state == S_TURN && turn_cnt != 4'd0)
                turn_cnt <= turn_cnt - 4'd1;
            if (state == S_IDLE)
                hold_cnt <= '0;
            else if (hold_cnt != 16'hFFFF)
                hold_cnt <= hold_cnt + 16'd1;
        end
    end

    // Registered pin drive; only the current owner reaches the port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pmod_tri_t <= '1;
            pmod_tri_o <= '0;
        end else begin
            unique case (state)
                S_GRANT0: begin
                    pmod_tri_t <= rq0_tri_t;
                    pmod_tri_o <= rq0_tri_o;
                end
                S_GRANT1: begin
                    pmod_tri_t <= rq1_tri_t;
                    pmod_tri_o <= rq1_tri_o;
                end
                default: begin
                    pmod_tri_t <= '1;
                    pmod_tri_o <= '0;
                end
            endcase
        end
    end

    // Pin input synchroniser chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pmod_tri_i;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

endmodule

// File: tb/tb_pmod_gpio_arbiter.sv
// tb_pmod_gpio_arbiter: directed bench for the Pmod GPIO owner arbiter.
// Instance a uses MAX_HOLD=8, instance b uses MAX_HOLD=0; both share inputs.
module tb_pmod_gpio_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [7:0] rq0_t, rq1_t, rq0_o, rq1_o, pin_i;

    logic       gnt0, gnt1, preempt;
    logic [7:0] rq0_i, rq1_i, pmod_t, pmod_o;
    logic       gnt0_b, gnt1_b, preempt_b;
    logic [7:0] rq0_i_b, rq1_i_b, pmod_t_b, pmod_o_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pmod_gpio_arbiter #(
        .WIDTH(8), .TURNAROUND(2), .MAX_HOLD(8), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .gnt0(gnt0), .gnt1(gnt1), .preempt(preempt),
        .rq0_tri_t(rq0_t), .rq1_tri_t(rq1_t),
        .rq0_tri_o(rq0_o), .rq1_tri_o(rq1_o),
        .rq0_tri_i(rq0_i), .rq1_tri_i(rq1_i),
        .pmod_tri_t(pmod_t), .pmod_tri_o(pmod_o), .pmod_tri_i(pin_i)
    );

    pmod_gpio_arbiter #(
        .WIDTH(8), .TURNAROUND(2), .MAX_HOLD(0), .SYNC_STAGES(2)
    ) dut_b (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .preempt(preempt_b),
        .rq0_tri_t(rq0_t), .rq1_tri_t(rq1_t),
        .rq0_tri_o(rq0_o), .rq1_tri_o(rq1_o),
        .rq0_tri_i(rq0_i_b), .rq1_tri_i(rq1_i_b),
        .pmod_tri_t(pmod_t_b), .pmod_tri_o(pmod_o_b), .pmod_tri_i(pin_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        rq0_t = 8'hFF;
        rq1_t = 8'hFF;
        rq0_o = 8'h00;
        rq1_o = 8'h00;
        pin_i = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({gnt0, gnt1, preempt} !== 3'b000) begin
            failures++;
            $display("FAIL reset_gnt got=%b exp=000", {gnt0, gnt1, preempt});
        end
        checks++;
        if ({pmod_t, pmod_o} !== 16'hFF00) begin
            failures++;
            $display("FAIL reset_pins got=%h exp=ff00", {pmod_t, pmod_o});
        end
        checks++;
        if ({rq0_i, rq1_i} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_rqi got=%h exp=0000", {rq0_i, rq1_i});
        end
        rq0_t = 8'h00;
        rq0_o = 8'h3C;
        pin_i = 8'hFF;
        req0  = 1'b1;
        tick();
        tick();
        checks++;
        if ({gnt0, pmod_t, rq0_i} !== {1'b1, 8'h00, 8'hFF}) begin
            failures++;
            $display("FAIL pre_rst_own got=%h exp=100ff", {gnt0, pmod_t, rq0_i});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt0, pmod_t, pmod_o, rq0_i} !== {1'b0, 8'hFF, 8'h00, 8'h00}) begin
            failures++;
            $display("FAIL async_rst got=%h exp=0ff0000",
                     {gnt0, pmod_t, pmod_o, rq0_i});
        end
    endtask

    task automatic test_single_owner();
        do_reset();
        rq0_t = 8'hF0;
        rq0_o = 8'h5A;
        pin_i = 8'h77;
        req0  = 1'b1;
        tick();
        checks++;
        if ({gnt0, gnt1, pmod_t} !== {2'b10, 8'hFF}) begin
            failures++;
            $display("FAIL first_gnt got=%h exp=2ff", {gnt0, gnt1, pmod_t});
        end
        tick();
        checks++;
        if ({pmod_t, pmod_o} !== 16'hF05A) begin
            failures++;
            $display("FAIL owner_pins got=%h exp=f05a", {pmod_t, pmod_o});
        end
        checks++;
        if ({rq0_i, rq1_i} !== 16'h7700) begin
            failures++;
            $display("FAIL owner_rqi got=%h exp=7700", {rq0_i, rq1_i});
        end
        req0 = 1'b0;
        tick();
        checks++;
        if ({gnt0, pmod_t, pmod_o} !== {1'b0, 8'hF0, 8'h5A}) begin
            failures++;
            $display("FAIL release_m1 got=%h exp=0f05a", {gnt0, pmod_t, pmod_o});
        end
        tick();
        checks++;
        if ({pmod_t, pmod_o} !== 16'hFF00) begin
            failures++;
            $display("FAIL release_m2 got=%h exp=ff00", {pmod_t, pmod_o});
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        rq0_t = 8'h00;
        rq0_o = 8'h11;
        rq1_t = 8'h0F;
        rq1_o = 8'h22;
        req0  = 1'b1;
        req1  = 1'b1;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            failures++;
            $display("FAIL tie_first got=%b exp=10", {gnt0, gnt1});
        end
        tick();
        tick();
        req0 = 1'b0;
        tick();
        checks++;
        if ({gnt0, gnt1, pmod_t} !== {2'b00, 8'h00}) begin
            failures++;
            $display("FAIL hand_m1 got=%h exp=000", {gnt0, gnt1, pmod_t});
        end
        tick();
        checks++;
        if ({gnt0, gnt1, pmod_t} !== {2'b00, 8'hFF}) begin
            failures++;
            $display("FAIL hand_m2 got=%h exp=0ff", {gnt0, gnt1, pmod_t});
        end
        tick();
        checks++;
        if ({gnt0, gnt1, pmod_t} !== {2'b00, 8'hFF}) begin
            failures++;
            $display("FAIL hand_m3 got=%h exp=0ff", {gnt0, gnt1, pmod_t});
        end
        tick();
        checks++;
        if ({gnt0, gnt1, pmod_t} !== {2'b01, 8'hFF}) begin
            failures++;
            $display("FAIL hand_m4 got=%h exp=1ff", {gnt0, gnt1, pmod_t});
        end
        tick();
        checks++;
        if ({pmod_t, pmod_o} !== 16'h0F22) begin
            failures++;
            $display("FAIL hand_m5 got=%h exp=0f22", {pmod_t, pmod_o});
        end
        checks++;
        if (preempt !== 1'b0) begin
            failures++;
            $display("FAIL hand_preempt got=%b exp=0", preempt);
        end
    endtask

    task automatic test_round_robin();
        logic exp_owner;
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        tick();
        exp_owner = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({gnt0, gnt1} !== {~exp_owner, exp_owner}) begin
                failures++;
                $display("FAIL rr_owner%0d got=%b exp=%b", i, {gnt0, gnt1},
                         {~exp_owner, exp_owner});
            end
            if (exp_owner) req1 = 1'b0;
            else           req0 = 1'b0;
            tick();
            req0 = 1'b1;
            req1 = 1'b1;
            checks++;
            if ({gnt0, gnt1} !== 2'b00) begin
                failures++;
                $display("FAIL rr_turn%0d got=%b exp=00", i, {gnt0, gnt1});
            end
            tick();
            tick();
            tick();
            exp_owner = ~exp_owner;
        end
    endtask

    task automatic test_preempt();
        int n0, np, pat, g1at, ovl, nb0, npb;
        do_reset();
        req0 = 1'b1;
        tick();
        n0   = gnt0 ? 1 : 0;
        nb0  = gnt0_b ? 1 : 0;
        np   = 0;
        npb  = 0;
        pat  = -1;
        g1at = -1;
        ovl  = 0;
        req1 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (gnt0) n0++;
            if (preempt) begin
                np++;
                pat = k;
            end
            if (gnt1 && g1at < 0) g1at = k;
            if (gnt0 && gnt1) ovl++;
            if (gnt0_b) nb0++;
            if (preempt_b) npb++;
        end
        checks++;
        if (n0 !== 8) begin
            failures++;
            $display("FAIL hold_len got=%0d exp=8", n0);
        end
        checks++;
        if (np !== 1 || pat !== 8) begin
            failures++;
            $display("FAIL preempt_pulse got=%0d@%0d exp=1@8", np, pat);
        end
        checks++;
        if (g1at !== 11) begin
            failures++;
            $display("FAIL preempt_next got=%0d exp=11", g1at);
        end
        checks++;
        if (ovl !== 0) begin
            failures++;
            $display("FAIL overlap got=%0d exp=0", ovl);
        end
        checks++;
        if (nb0 !== 13 || npb !== 0) begin
            failures++;
            $display("FAIL nohold got=%0d/%0d exp=13/0", nb0, npb);
        end
    endtask

    task automatic test_input_sync();
        do_reset();
        req1 = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (rq1_i !== 8'h00) begin
            failures++;
            $display("FAIL sync_pre got=%h exp=00", rq1_i);
        end
        pin_i = 8'hA5;
        tick();
        checks++;
        if (rq1_i !== 8'h00) begin
            failures++;
            $display("FAIL sync_s1 got=%h exp=00", rq1_i);
        end
        tick();
        checks++;
        if ({rq1_i, rq0_i} !== 16'hA500) begin
            failures++;
            $display("FAIL sync_s2 got=%h exp=a500", {rq1_i, rq0_i});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_owner();
        test_simultaneous();
        test_round_robin();
        test_preempt();
        test_input_sync();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pmod_gpio_arbiter.md
# pmod_gpio_arbiter

Shares one 8-pin Pmod GPIO port (tri-state T/O/I triplet) between two requesters, e.g. an AXI GPIO and a hardware pattern engine. Grants exclusive ownership with registered request/grant handshakes, round-robin fairness and optional hold-time preemption. Inserts a high-Z turnaround between owners so two drivers never overlap. Synchronises pin inputs before returning them to the owner. Sits between the requesters and the Pmod top/bottom-row bit split.

## Interface
- WIDTH, 8, pin count of the shared port
- TURNAROUND, 2, cycles spent in TURN between owners; legal 1..15
- MAX_HOLD, 0, cycles an owner may hold while the other requester waits before preemption; 0 disables; legal 0..65535
- SYNC_STAGES, 2, flops in the pin-input synchroniser; legal 2..4
- clk  in  1  single clock for all logic
- rst  in  1  asynchronous, active-high reset
- req0, req1  in  1  ownership request, level; held high for the whole ownership
- gnt0, gnt1  out  1  registered grant; at most one high
- preempt  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD
- rq0_tri_t, rq1_tri_t  in  WIDTH  requester tri-state enables, 1 = high-Z
- rq0_tri_o, rq1_tri_o  in  WIDTH  requester output values
- rq0_tri_i, rq1_tri_i  out  WIDTH  synchronised pin values; owner only, else 0
- pmod_tri_t  out  WIDTH  pin enables to the port
- pmod_tri_o  out  WIDTH  pin output values to the port
- pmod_tri_i  in  WIDTH  raw pin inputs, asynchronous to clk

## Operation
- States: IDLE, GRANT0, GRANT1, TURN. Registers: last_owner, turn counter (4 bit), hold counter (16 bit, saturating).
- Reset values: state IDLE, gnt0=gnt1=0, preempt=0, pmod_tri_t all ones, pmod_tri_o 0, synchroniser flops 0, rq*_tri_i 0, last_owner=1 (req0 wins the first tie).
- IDLE: req0 only → GRANT0; req1 only → GRANT1; both → the requester that is not last_owner; neither → stay.
- GRANTk: gntk=1. Set last_owner=k on entry. Hold counter clears on entry and increments each cycle.
  - reqk low → TURN.
  - MAX_HOLD≠0, other request high and hold count ≥ MAX_HOLD−1 → TURN, preempt pulses on the first TURN cycle.
  - Owner drop and preemption in the same cycle → TURN without preempt.
- TURN: gnt0=gnt1=0. Counter loads TURNAROUND−1 on entry and decrements; at 0 → IDLE.
- A preempted requester that keeps req high is re-arbitrated in IDLE. Round-robin then favours the waiting requester.
- Pin drive (registered): in GRANTk, pmod_tri_t/o ← rqk_tri_t/o. In all other states, pmod_tri_t ← all ones and pmod_tri_o ← 0.
- Input path: pmod_tri_i passes through a SYNC_STAGES flop chain. rqk_tri_i = gntk ? sync_out : 0.
- req toggling while not granted is legal. Only the sampled level matters.
- rst asserted mid-ownership or mid-TURN: all outputs take reset values immediately, asynchronously. Pins go high-Z immediately.

## Timing
- Grant latency: req sampled high at edge n → gnt high from cycle n+1, if IDLE at edge n.
- Pin latency: pmod outputs follow the owner's rq*_tri_* one cycle behind. The first gnt cycle still shows high-Z.
- Release: req low sampled at edge m → gnt low in cycle m+1 and pins still show the owner's last values in cycle m+1. Pins are high-Z from m+2.
- Handoff after release at edge m: TURN occupies cycles m+1..m+TURNAROUND, IDLE is at m+TURNAROUND+1, and the next gnt rises at m+TURNAROUND+2. Pins are driven by the next owner from m+TURNAROUND+3.
- Preemption: an owner granted from cycle g keeps its grant for exactly MAX_HOLD cycles (g..g+MAX_HOLD−1) when the other request is held high throughout.
- rq*_tri_i latency: SYNC_STAGES cycles from pmod_tri_i.

## Test plan
- Reset: assert rst mid-GRANT0 with rq0_tri_t=0x00 → pmod_tri_t=0xFF, gnt0=0 and rq0_tri_i=0, all without waiting for a clock edge.
- Single owner: req0 at edge 5 with rq0_tri_t=0xF0, rq0_tri_o=0x5A → gnt0 in cycle 6; pmod_tri_t=0xF0, pmod_tri_o=0x5A from cycle 7; rq1_tri_i stays 0.
- Simultaneous first request: req0=req1=1 from reset → GRANT0. Drop req0 with TURNAROUND=2 → gnt1 four cycles after the drop edge; pins 0xFF in between.
- Round-robin: both held, owners drop alternately → grants alternate 0,1,0,1 and gnt0&gnt1 is never 1.
- Preemption: MAX_HOLD=8, req0 held, req1 raised → gnt0 high exactly 8 cycles, one preempt pulse, gnt1 follows after TURN. Same test with MAX_HOLD=0 → no preempt.
- Input sync: owner 1, pmod_tri_i steps 0x00→0xA5 → rq1_tri_i=0xA5 exactly SYNC_STAGES cycles later and rq0_tri_i=0.
